// File: rtl/ln_pkg.sv
// ln_pkg: shared definitions for the layernorm statistics front-end.
//   - bf16 constants, FSM state encoding, bf16 format parameters
//   - bf16 add/sub/mult helpers: round-to-nearest-even, subnormals flushed
//     to zero, overflow saturates to infinity (ieee_compliance 0 behaviour)
package ln_pkg;

    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;

    localparam int unsigned SIG_W = 7;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned IEEE  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_MEAN,
        ST_SQR,
        ST_SUB,
        ST_EPS,
        ST_OUT
    } ln_state_e;

    // Zero test; with IEEE == 0 any zero exponent (subnormal) counts as zero.
    function automatic logic bf16_is_zero(input logic [15:0] x);
        return (x[14:7] == '0) && (IEEE == 0 || x[6:0] == '0);
    endfunction

    // RNE rounding of a normalised 1.m significand plus guard/sticky, then range check.
    function automatic logic [15:0] bf16_round(input logic s, input int e,
                                               input logic [SIG_W:0] m,
                                               input logic g, input logic st);
        logic [SIG_W+1:0] mr;
        int ex;
        ex = e;
        mr = {1'b0, m} + 9'(g & (st | m[0]));
        if (mr[SIG_W+1]) begin
            mr = mr >> 1;
            ex = ex + 1;
        end
        if (ex <= 0) return {s, 15'h0000};
        if (ex >= 255) return {s, 8'hFF, 7'h00};
        return {s, 8'(ex), mr[SIG_W-1:0]};
    endfunction

    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [2*SIG_W+1:0] p;
        logic s;
        int e;
        s = a[15] ^ b[15];
        if (bf16_is_zero(a) || bf16_is_zero(b)) return {s, 15'h0000};
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) return bf16_round(s, e + 1, p[15:8], p[7], |p[6:0]);
        return bf16_round(s, e, p[14:7], p[6], |p[5:0]);
    endfunction

    // Align into a 24-bit field (16 extra bits + sticky) so RNE is exact.
    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [EXP_W-1:0] d;
        logic [23:0] mx, my;
        logic [24:0] r;
        int e;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (bf16_is_zero(x)) return BF16_ZERO;
        if (bf16_is_zero(y)) return x;
        d  = x[14:7] - y[14:7];
        mx = {1'b1, x[6:0], 16'h0000};
        my = {1'b1, y[6:0], 16'h0000};
        if (d > 8'd23) my = 24'd1;
        else my = (my >> d) | 24'(|(my & ((24'd1 << d) - 24'd1)));
        r = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        if (r == '0) return BF16_ZERO;
        e = int'(x[14:7]);
        if (r[24]) begin
            r = {1'b0, r[24:2], r[1] | r[0]};
            e = e + 1;
        end
        // Cancellation only happens with d <= 1, where no sticky was lost.
        for (int i = 0; i < 23; i++) begin
            if (!r[23]) begin
                r = r << 1;
                e = e - 1;
            end
        end
        return bf16_round(x[15], e, r[23:16], r[15], |r[14:0]);
    endfunction

    function automatic logic [15:0] bf16_sub(input logic [15:0] a, input logic [15:0] b);
        return bf16_add(a, b ^ 16'h8000);
    endfunction

endpackage

// File: rtl/bf16_sq_accum.sv
// bf16_sq_accum: running sum and sum-of-squares of a bf16 stream.
//   clk, rst_n : clock, async active-low reset
//   x_i        : bf16 element
//   load_i     : start a new packet (sum<=x, sumsq<=x*x)
//   acc_i      : accumulate (sum+=x, sumsq+=x*x); load_i has priority
//   sum_o      : registered sum
//   sumsq_o    : registered sum of squares
module bf16_sq_accum
    import ln_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] x_i,
    input  logic        load_i,
    input  logic        acc_i,
    output logic [15:0] sum_o,
    output logic [15:0] sumsq_o
);

    logic [15:0] sq_c;
    logic [15:0] sum_q, sum_d;
    logic [15:0] sumsq_q, sumsq_d;

    // Squarer and the two accumulating adders.
    always_comb begin
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        sq_c    = bf16_mul(x_i, x_i);
        if (load_i) begin
            sum_d   = x_i;
            sumsq_d = sq_c;
        end else if (acc_i) begin
            sum_d   = bf16_add(sum_q, x_i);
            sumsq_d = bf16_add(sumsq_q, sq_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= BF16_ZERO;
            sumsq_q <= BF16_ZERO;
        end else begin
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
        end
    end

    assign sum_o   = sum_q;
    assign sumsq_o = sumsq_q;

endmodule

// File: rtl/ln_stat_gen.sv
// ln_stat_gen: layernorm statistics front-end. Accumulates a bf16 packet,
// then derives mean and (E[x^2] - mean^2 + eps) for the invsqrt pipeline.
//   clk, rst_n                    : clock, async active-low reset
//   in_data_i/in_vld_i/in_last_i  : element stream, in_rdy_o accepts
//   inv_n_i, eps_i                : bf16 1/N and epsilon, sampled on first beat
//   mean_o, var_eps_o, stat_vld_o : result, held until stat_rdy_i
//   elem_cnt_o                    : elements accepted in current/last packet
//   len_err_o                     : one-cycle pulse when truncated at MAX_LEN
// Build option: LN_STAT_CLAMP_EN clamps a negative variance to zero before eps.
module ln_stat_gen
    import ln_pkg::*;
#(
    parameter  int unsigned MAX_LEN = 1024,
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      in_data_i,
    input  logic             in_vld_i,
    input  logic             in_last_i,
    output logic             in_rdy_o,
    input  logic [15:0]      inv_n_i,
    input  logic [15:0]      eps_i,
    output logic [15:0]      mean_o,
    output logic [15:0]      var_eps_o,
    output logic             stat_vld_o,
    input  logic             stat_rdy_i,
    output logic [CNT_W-1:0] elem_cnt_o,
    output logic             len_err_o
);

    ln_state_e        state_q, state_d;
    logic [15:0]      inv_n_q, inv_n_d, eps_q, eps_d;
    logic [15:0]      mean_q, mean_d, ex2_q, ex2_d, msq_q, msq_d;
    logic [15:0]      var_q, var_d, var_eps_q, var_eps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
    logic             stat_vld_q, stat_vld_d, in_rdy_q, in_rdy_d, len_err_q, len_err_d;
    logic             accept_c, load_c, acc_c;
    logic [15:0]      sum_c, sumsq_c;

    bf16_sq_accum u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .x_i     (in_data_i),
        .load_i  (load_c),
        .acc_i   (acc_c),
        .sum_o   (sum_c),
        .sumsq_o (sumsq_c)
    );

    // Next-state and datapath control; post-processing is one stage per state.
    always_comb begin
        state_d    = state_q;
        inv_n_d    = inv_n_q;
        eps_d      = eps_q;
        mean_d     = mean_q;
        ex2_d      = ex2_q;
        msq_d      = msq_q;
        var_d      = var_q;
        var_eps_d  = var_eps_q;
        cnt_d      = cnt_q;
        stat_vld_d = stat_vld_q;
        len_err_d  = 1'b0;
        load_c     = 1'b0;
        acc_c      = 1'b0;
        accept_c   = in_vld_i & in_rdy_q;
        cnt_inc_c  = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_IDLE: if (accept_c) begin
                load_c    = 1'b1;
                inv_n_d   = inv_n_i;
                eps_d     = eps_i;
                cnt_d     = CNT_W'(1);
                len_err_d = !in_last_i && (MAX_LEN == 1);
                state_d   = (in_last_i || MAX_LEN == 1) ? ST_MEAN : ST_ACC;
            end
            ST_ACC: if (accept_c) begin
                acc_c = 1'b1;
                cnt_d = cnt_inc_c;
                if (in_last_i) begin
                    state_d = ST_MEAN;
                end else if (cnt_inc_c == CNT_W'(MAX_LEN)) begin
                    // Truncate: the MAX_LEN-th beat closes the packet.
                    len_err_d = 1'b1;
                    state_d   = ST_MEAN;
                end
            end
            ST_MEAN: begin
                mean_d  = bf16_mul(sum_c, inv_n_q);
                ex2_d   = bf16_mul(sumsq_c, inv_n_q);
                state_d = ST_SQR;
            end
            ST_SQR: begin
                msq_d   = bf16_mul(mean_q, mean_q);
                state_d = ST_SUB;
            end
            ST_SUB: begin
                var_d = bf16_sub(ex2_q, msq_q);
`ifdef LN_STAT_CLAMP_EN
                if (var_d[15]) var_d = BF16_ZERO;
`endif
                state_d = ST_EPS;
            end
            ST_EPS: begin
                var_eps_d  = bf16_add(var_q, eps_q);
                stat_vld_d = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: if (stat_rdy_i) begin
                stat_vld_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_rdy_d = (state_d == ST_IDLE) || (state_d == ST_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inv_n_q    <= BF16_ZERO;
            eps_q      <= BF16_ZERO;
            mean_q     <= BF16_ZERO;
            ex2_q      <= BF16_ZERO;
            msq_q      <= BF16_ZERO;
            var_q      <= BF16_ZERO;
            var_eps_q  <= BF16_ZERO;
            cnt_q      <= '0;
            stat_vld_q <= 1'b0;
            in_rdy_q   <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inv_n_q    <= inv_n_d;
            eps_q      <= eps_d;
            mean_q     <= mean_d;
            ex2_q      <= ex2_d;
            msq_q      <= msq_d;
            var_q      <= var_d;
            var_eps_q  <= var_eps_d;
            cnt_q      <= cnt_d;
            stat_vld_q <= stat_vld_d;
            in_rdy_q   <= in_rdy_d;
            len_err_q  <= len_err_d;
        end
    end

    assign in_rdy_o   = in_rdy_q;
    assign mean_o     = mean_q;
    assign var_eps_o  = var_eps_q;
    assign stat_vld_o = stat_vld_q;
    assign elem_cnt_o = cnt_q;
    assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_ln_stat_gen.sv
// tb_ln_stat_gen: directed and randomized packets against a real-number
// model of the statistics (each bf16 operation rounded to nearest-even).
module tb_ln_stat_gen;

    localparam int unsigned MAXL = 4;
    localparam int unsigned CW   = $clog2(MAXL) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   in_data = '0;
    logic          in_vld = 1'b0;
    logic          in_last = 1'b0;
    logic          in_rdy;
    logic [15:0]   in_inv = '0;
    logic [15:0]   in_eps = '0;
    logic [15:0]   mean;
    logic [15:0]   var_eps;
    logic          stat_vld;
    logic          stat_rdy = 1'b0;
    logic [CW-1:0] elem_cnt;
    logic          len_err;

    int total = 0;
    int bad = 0;
    logic [15:0] pkt[$];

    ln_stat_gen #(.MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (in_data),
        .in_vld_i   (in_vld),
        .in_last_i  (in_last),
        .in_rdy_o   (in_rdy),
        .inv_n_i    (in_inv),
        .eps_i      (in_eps),
        .mean_o     (mean),
        .var_eps_o  (var_eps),
        .stat_vld_o (stat_vld),
        .stat_rdy_i (stat_rdy),
        .elem_cnt_o (elem_cnt),
        .len_err_o  (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real b2r(input logic [15:0] b);
        real v;
        int e;
        if (b[14:7] == 8'h00) return 0.0;
        v = 1.0 + real'(b[6:0]) / 128.0;
        e = int'(b[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2b(input real r);
        real a, m;
        int e, mi;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m  = a * 128.0;
        mi = int'(m);
        if (real'(mi) > m) mi--;
        if ((m - real'(mi) > 0.5) || (m - real'(mi) == 0.5 && mi[0])) mi++;
        if (mi == 256) begin mi = 128; e++; end
        if (e + 127 <= 0) return {s, 15'h0000};
        if (e + 127 >= 255) return {s, 8'hFF, 7'h00};
        return {s, 8'(e + 127), 7'(mi - 128)};
    endfunction

    function automatic real rb(input real r);
        return b2r(r2b(r));
    endfunction

    // Reference statistics of the (possibly truncated) packet in pkt.
    function automatic void model(output logic [15:0] em, output logic [15:0] ev);
        real sum, sq, x, inv, ex2, msq;
        logic [15:0] vr;
        int n;
        n   = (pkt.size() > MAXL) ? MAXL : pkt.size();
        inv = b2r(in_inv);
        sum = 0.0;
        sq  = 0.0;
        for (int i = 0; i < n; i++) begin
            x   = b2r(pkt[i]);
            sum = (i == 0) ? x : rb(sum + x);
            sq  = (i == 0) ? rb(x * x) : rb(sq + rb(x * x));
        end
        em  = r2b(sum * inv);
        ex2 = rb(sq * inv);
        msq = rb(b2r(em) * b2r(em));
        vr  = r2b(ex2 - msq);
`ifdef LN_STAT_CLAMP_EN
        if (vr[15]) vr = 16'h0000;
`endif
        ev = r2b(b2r(vr) + b2r(in_eps));
    endfunction

    task automatic send(input bit with_last);
        int n, w;
        bit acc;
        n = (pkt.size() > MAXL) ? MAXL : pkt.size();
        for (int i = 0; i < n; i++) begin
            in_data = pkt[i];
            in_last = with_last && (i == n - 1);
            in_vld  = 1'b1;
            acc = 1'b0;
            w   = 0;
            while (!acc && w < 50) begin
                @(negedge clk);
                acc = in_rdy;
                @(posedge clk);
                #1;
                w++;
            end
            chk("beat_accept", 32'(acc), 32'd1);
            chk("len_err", 32'(len_err), 32'(!in_last && i == MAXL - 1));
            in_vld  = 1'b0;
            in_last = 1'b0;
        end
    endtask

    // rd < 0: stat_rdy already high when the result appears; else held low rd cycles.
    task automatic run_packet(input string tag, input bit with_last,
                              input logic [15:0] em, input logic [15:0] ev, input int rd);
        int lat, n;
        bit stable;
        n = (pkt.size() > MAXL) ? MAXL : pkt.size();
        stat_rdy = (rd < 0);
        send(with_last);
        if (!with_last && pkt.size() > MAXL) begin
            in_data = pkt[MAXL];
            in_vld  = 1'b1;
            chk({tag, "_rdy_blocked"}, 32'(in_rdy), 32'd0);
            @(negedge clk);
            chk({tag, "_rdy_blocked2"}, 32'(in_rdy), 32'd0);
            in_vld = 1'b0;
            @(posedge clk);
            #1;
            lat = 1;
        end else begin
            lat = 0;
        end
        while (!stat_vld && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_mean"}, 32'(mean), 32'(em));
        chk({tag, "_var_eps"}, 32'(var_eps), 32'(ev));
        chk({tag, "_elem_cnt"}, 32'(elem_cnt), 32'(n));
        chk({tag, "_rdy_out"}, 32'(in_rdy), 32'd0);
        if (rd >= 0) begin
            stable = 1'b1;
            repeat (rd) begin
                @(posedge clk);
                #1;
                stable &= stat_vld && !in_rdy && mean == em && var_eps == ev;
            end
            chk({tag, "_hold"}, 32'(stable), 32'd1);
            stat_rdy = 1'b1;
        end
        @(posedge clk);
        #1;
        stat_rdy = 1'b0;
        chk({tag, "_vld_drop"}, 32'(stat_vld), 32'd0);
        chk({tag, "_rdy_idle"}, 32'(in_rdy), 32'd1);
        chk({tag, "_cnt_hold"}, 32'(elem_cnt), 32'(n));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_vld"}, 32'(stat_vld), 32'd0);
        chk({tag, "_rdy"}, 32'(in_rdy), 32'd0);
        chk({tag, "_mean"}, 32'(mean), 32'd0);
        chk({tag, "_var_eps"}, 32'(var_eps), 32'd0);
        chk({tag, "_cnt"}, 32'(elem_cnt), 32'd0);
        chk({tag, "_len_err"}, 32'(len_err), 32'd0);
    endtask

    task automatic load_basic();
        pkt = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};
        in_inv = 16'h3E80;
        in_eps = 16'h0000;
    endtask

    initial begin
        logic [15:0] em, ev;
        int len, rd;
        bit wl;
        bit seen;

        // Reset state
        #1;
        check_cleared("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_rdy", 32'(in_rdy), 32'd1);

        load_basic();
        run_packet("basic", 1'b1, 16'h4020, 16'h3FA0, 2);

        pkt = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        in_inv = 16'h3E80;
        in_eps = 16'h3A80;
        run_packet("const", 1'b1, 16'h4000, 16'h3A80, -1);

        pkt = '{16'h4040};
        in_inv = 16'h3F80;
        in_eps = 16'h0000;
        run_packet("single", 1'b1, 16'h4040, 16'h0000, 10);

        pkt = '{16'h3F80, 16'h3F80};
`ifdef LN_STAT_CLAMP_EN
        run_packet("clamp", 1'b1, 16'h4000, 16'h0000, 1);
`else
        run_packet("clamp", 1'b1, 16'h4000, 16'hC000, 1);
`endif

        pkt = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        in_inv = 16'h3E80;
        run_packet("ovf", 1'b0, 16'h3F80, 16'h0000, 2);

        // Reset while the packet sits in SQR; nothing may emerge afterwards.
        load_basic();
        send(1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen |= stat_vld;
        end
        chk("mid_rst_no_vld", 32'(seen), 32'd0);
        load_basic();
        run_packet("after_rst", 1'b1, 16'h4020, 16'h3FA0, 0);

        for (int t = 0; t < 24; t++) begin
            wl  = (t % 5 != 4);
            len = wl ? int'($urandom_range(MAXL, 1)) : MAXL + 1;
            pkt = {};
            for (int i = 0; i < len; i++)
                pkt.push_back({1'($urandom), 8'($urandom_range(134, 120)), 7'($urandom)});
            in_inv = r2b(1.0 / real'((len > MAXL) ? MAXL : len));
            in_eps = {1'b0, 8'($urandom_range(120, 100)), 7'($urandom)};
            model(em, ev);
            rd = (t % 3 == 0) ? -1 : int'($urandom_range(4, 0));
            run_packet($sformatf("rand%0d", t), wl, em, ev, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ln_stat_gen.md
Name: ln_stat_gen

Overview:
- Statistics front-end of the layernorm vector engine; produces the operand for the bf16 inverse-square-root pipeline.
- Consumes one bf16 element per cycle over a valid/ready stream and accumulates sum and sum-of-squares.
- On the packet's last beat, derives mean and (variance + eps).
- Presents both results on a held valid/ready output: var_eps feeds the invsqrt x/x_vld input, mean goes to the normalize stage.

Parameters:
- MAX_LEN, 1024, maximum elements per packet.
- CNT_W, $clog2(MAX_LEN)+1, element counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_data  in  16  bf16 element (sign 1, exp 8, frac 7).
- in_vld  in  1  element valid.
- in_last  in  1  final element of packet.
- in_rdy  out  1  block accepts element.
- inv_n  in  16  bf16 1/N, sampled on first beat.
- eps  in  16  bf16 epsilon, sampled on first beat.
- mean  out  16  bf16 mean.
- var_eps  out  16  bf16 E[x²]−mean²+eps.
- stat_vld  out  1  mean/var_eps valid, held until taken.
- stat_rdy  in  1  downstream accepts result.
- elem_cnt  out  CNT_W  elements accepted in current or last packet.
- len_err  out  1  one-cycle pulse: packet truncated at MAX_LEN.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0, in_rdy 0 during reset, state IDLE, accumulators 0.
- Beat acceptance: beat accepted iff in_vld & in_rdy; in_rdy = 1 in IDLE and ACC only.
- FSM states: IDLE, ACC, MEAN, SQR, SUB, EPS, OUT.
- IDLE:
  - On accept: sum<=x; sumsq<=x*x; inv_n and eps registered; elem_cnt<=1.
  - Next state: ACC, or MEAN if in_last.
- ACC:
  - On accept: sum<=sum+x; sumsq<=sumsq+x*x; elem_cnt++.
  - in_last moves to MEAN.
  - If elem_cnt reaches MAX_LEN without in_last: treat the beat as last, pulse len_err, go to MEAN.
- Post-processing, one cycle per state, results registered:
  - MEAN: mean<=sum*inv_n; ex2<=sumsq*inv_n.
  - SQR: msq<=mean*mean.
  - SUB: var<=ex2−msq.
  - EPS: var_eps<=var+eps.
  - Then OUT.
- OUT:
  - stat_vld=1; mean and var_eps stable.
  - On stat_rdy: stat_vld drops next cycle and state returns to IDLE.
  - No new beat is accepted until return to IDLE.
- Latency: stat_vld asserts 4 edges after the edge that accepted the last beat.
- Arithmetic:
  - All arithmetic is bf16 with DW_fp_add/sub/mult, sig_width 7, exp_width 8, ieee_compliance 0, rnd 3'b000 (RNE).
  - Combinational units feed registers; there is no multi-cycle path.
- Single-element packet: IDLE goes directly to MEAN.
- Simultaneous stat_rdy in the first OUT cycle: taken immediately; stat_vld is high for exactly 1 cycle.
- Reset mid-packet or in OUT: abort, outputs cleared, no partial result emitted.
- elem_cnt holds its final value until the next packet's first beat.

Optional Feature:
- Macro: LN_STAT_CLAMP_EN.
- Defined: in SUB, if ex2−msq is negative (sign bit set), var is forced to 0x0000 before the eps add.
- Undefined: the raw subtraction result propagates, and negative var_eps is possible.

Decomposition:
- Package ln_pkg:
  - bf16 constants BF16_ZERO=16'h0000 and BF16_ONE=16'h3F80.
  - FSM state encoding.
  - DW parameter constants (SIG_W=7, EXP_W=8, IEEE=0).
- Sub-module bf16_sq_accum: squarer plus two adders plus sum/sumsq registers, with load/accumulate control.

Test Plan:
- Basic packet:
  - Stimulus: inv_n=0x3E80, eps=0x0000, beats 0x3F80, 0x4000, 0x4040, 0x4080 (last).
  - Expected: mean=0x4020, var_eps=0x3FA0, elem_cnt=4, stat_vld 4 cycles after the last accept.
- Constant packet:
  - Stimulus: 4×0x4000, inv_n=0x3E80, eps=0x3A80.
  - Expected: mean=0x4000, var_eps=0x3A80.
- Backpressure and single element:
  - Stimulus: single beat 0x4040 with in_last, inv_n=0x3F80, eps=0; stat_rdy held low 10 cycles.
  - Expected: mean=0x4040, var_eps=0x0000; stat_vld and data stable the whole time; in_rdy=0; release, then IDLE with in_rdy=1.
- Clamp:
  - Stimulus: beats 0x3F80, 0x3F80 (last), inv_n=0x3F80, eps=0.
  - Expected: mean=0x4000 (sum 2 × 1/N 1.0); var_eps=0x0000 with LN_STAT_CLAMP_EN, 0xC000 without.
- Length overflow:
  - Stimulus: MAX_LEN=4, 5 beats of 0x3F80 with no in_last, inv_n=0x3E80.
  - Expected: len_err pulses on the 4th accept; in_rdy=0 for the 5th beat; mean=0x3F80.
- Reset mid-operation:
  - Stimulus: rst_n low during SQR of a packet.
  - Expected: all outputs 0, no stat_vld; the next packet from the Basic packet case produces correct results.
